modexp_ctrl_param: RTL and testbench
====================================

Name: modexp_ctrl_param

Overview:
- Parametrised modular-exponentiation controller computing x^e mod m with left-to-right square-and-multiply in the Montgomery domain.
- Drives an external Montgomery multiplier, instantiated alongside by the parent, through a start/done request port. The controller itself is width-generic and modulus-agnostic.
- Additions over the fixed 512-bit generation:
  - WIDTH and EXP_WIDTH parameters.
  - Leading-zero skip in normal mode.
  - Selectable constant-time mode with dummy multiplies.
  - A busy flag.

Parameters:
- WIDTH, 1024, operand/modulus width in bits.
- EXP_WIDTH, 1024, exponent width in bits. Bit counter width is derived as clog2(EXP_WIDTH+1).

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse, sampled only in IDLE
- const_time  input  1  mode, latched with start: 1 = process every exponent bit with a multiply each bit
- rmodm  input  WIDTH  R mod m, latched with start
- r2modm  input  WIDTH  R^2 mod m, latched with start
- x  input  WIDTH  base, latched with start
- exponent  input  EXP_WIDTH  exponent, latched with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  x^e mod m; holds until the next accepted start
- mul_start  output  1  one-cycle request pulse to the multiplier
- mul_a  output  WIDTH  multiplier operand a
- mul_b  output  WIDTH  multiplier operand b
- mul_done  input  1  one-cycle pulse from the multiplier; mul_result is valid in that cycle
- mul_result  input  WIDTH  multiplier result

Behaviour:
- Reset is one clock and asynchronous active-high. On assertion:
  - state goes to IDLE.
  - busy, done, mul_start, result, mul_a and mul_b are 0.
  - All internal registers (A, xm, latched inputs, counter) are 0.
  - Reset mid-operation aborts immediately. No done is produced.
- IDLE:
  - start=1 latches all inputs and const_time, sets bit index = EXP_WIDTH-1, and goes to TO_MONT.
  - start while not IDLE is ignored.
- Multiplier handshake, common to every state that multiplies:
  - On state entry, assert mul_start for exactly 1 cycle.
  - Hold mul_a and mul_b stable until mul_done.
  - mul_done outside a waiting state is ignored.
  - mul_done arriving in the same cycle as mul_start is not possible and is not required to be handled.
- TO_MONT:
  - Operands: a = x, b = r2modm.
  - On mul_done: xm <= mul_result and A <= rmodm.
  - Next state is SCAN if const_time=0, else SQR.
- SCAN (normal mode only): inspects one bit per cycle, MSB first.
  - Bit = 0: decrement the index and stay in SCAN.
  - Bit = 1: go to SQR.
  - Index passes bit 0 with all bits zero: go to FROM_MONT.
- SQR:
  - Operands: a = A, b = A. On mul_done: A <= mul_result.
  - Next state is MUL if the current bit = 1 or const_time = 1.
  - Otherwise advance to the next bit.
- MUL:
  - Operands: a = A, b = xm.
  - On mul_done: A <= mul_result only if the current bit = 1. In const-time mode with bit = 0 the result is discarded (dummy).
  - Then advance to the next bit.
- Advance:
  - index = 0: go to FROM_MONT.
  - Otherwise decrement the index and go to SQR. No rescan is done after the first 1.
- FROM_MONT:
  - Operands: a = A, b = 1 (zero-extended).
  - On mul_done: result <= mul_result, then go to DONE.
- DONE: done = 1 for 1 cycle, busy = 0, then IDLE.
- Multiply counts:
  - Normal mode: 2 + L + popcount(e), where L = bit length of e (L = 0 for e = 0).
  - Const-time mode: 2 + 2*EXP_WIDTH, independent of e.
- Cycle latency, start to done:
  - Sum of the multiplier latencies, plus 1 cycle per multiply for the issue, plus SCAN cycles (EXP_WIDTH - L, or EXP_WIDTH when e = 0), plus 1 for DONE.
- Special values:
  - e = 0 gives result = 1, for any x.
  - x >= m is not checked; the result is defined by the multiplier.
- busy is 1 in every state except IDLE and DONE.

Test Plan:
- Bench setup: WIDTH=16, EXP_WIDTH=8, m=239, R=2^16, behavioural Montgomery model with a random latency of 3-20 cycles.
- x=5, e=0x0D, const_time=0 -> result=109, done pulses once, exactly 9 mul_start pulses, 4 SCAN cycles.
- Same inputs, const_time=1 -> result=109, exactly 18 mul_start pulses, no SCAN cycles, A unchanged across dummy multiplies on bits 7..4 and 1.
- e=0x00, x=77, both modes -> result=1. Normal mode: 2 multiplies and 8 SCAN cycles. Const-time mode: 18 multiplies.
- e=0xFF, x=2, normal mode -> result = 2^255 mod 239, 18 multiplies. A second start pulse mid-run is ignored, and the result matches.
- Assert reset during the 5th multiply wait -> busy, mul_start and result are 0 asynchronously, no done. A fresh start with x=5, e=0x0D -> 109.
- Spurious mul_done pulse in IDLE, then a back-to-back start in the cycle after done -> no state change from the spurious pulse, and the second run completes correctly.

Source files
------------

// File: rtl/modexp_ctrl_param_if.sv
// Request/response and multiplier handshake bundle for the modexp controller.
interface modexp_ctrl_param_if #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
);
  logic                 start;
  logic                 const_time;
  logic [WIDTH-1:0]     rmodm;
  logic [WIDTH-1:0]     r2modm;
  logic [WIDTH-1:0]     x;
  logic [EXP_WIDTH-1:0] exponent;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_result;

  // Parent side: issues requests and hosts the Montgomery multiplier.
  modport master (
    output start, const_time, rmodm, r2modm, x, exponent,
    input  busy, done, result,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_result
  );

  // Controller side.
  modport slave (
    input  start, const_time, rmodm, r2modm, x, exponent,
    output busy, done, result,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_result
  );
endinterface

// File: rtl/modexp_ctrl_param.sv
// Left-to-right square-and-multiply controller for x^e mod m in the Montgomery
// domain; drives an external Montgomery multiplier through a start/done port.
module modexp_ctrl_param #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  modexp_ctrl_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(EXP_WIDTH + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TO_MONT   = 3'd1;
  localparam logic [2:0] S_SCAN      = 3'd2;
  localparam logic [2:0] S_SQR       = 3'd3;
  localparam logic [2:0] S_MUL       = 3'd4;
  localparam logic [2:0] S_FROM_MONT = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     xm_q, xm_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     rmodm_q, rmodm_d;
  logic [WIDTH-1:0]     r2modm_q, r2modm_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 ct_q, ct_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;

  logic cur_bit_c;
  logic next_bit_c;
  logic advance;
  logic issue;

  // Exponent bit at the current index and at the one below it.
  assign cur_bit_c  = |(exp_q & (EXP_WIDTH'(1) << idx_q));
  assign next_bit_c = |(exp_q & (EXP_WIDTH'(1) << (idx_q - CNT_W'(1))));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      xm_q        <= '0;
      x_q         <= '0;
      rmodm_q     <= '0;
      r2modm_q    <= '0;
      exp_q       <= '0;
      ct_q        <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      xm_q        <= xm_d;
      x_q         <= x_d;
      rmodm_q     <= rmodm_d;
      r2modm_q    <= r2modm_d;
      exp_q       <= exp_d;
      ct_q        <= ct_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  // Next-state, datapath updates and multiplier request generation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    xm_d        = xm_q;
    x_d         = x_q;
    rmodm_d     = rmodm_q;
    r2modm_d    = r2modm_q;
    exp_d       = exp_q;
    ct_d        = ct_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    advance     = 1'b0;
    issue       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d      = bus.x;
          rmodm_d  = bus.rmodm;
          r2modm_d = bus.r2modm;
          exp_d    = bus.exponent;
          ct_d     = bus.const_time;
          idx_d    = CNT_W'(EXP_WIDTH - 1);
          busy_d   = 1'b1;
          state_d  = S_TO_MONT;
          issue    = 1'b1;
        end
      end
      S_TO_MONT: begin
        if (bus.mul_done) begin
          xm_d = bus.mul_result;
          a_d  = rmodm_q;
          // A set top bit needs no scan cycle at all.
          if (ct_q || cur_bit_c) begin
            state_d = S_SQR;
            issue   = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // SCAN only ever sits on a zero bit; the bit below is examined as the
        // index moves, so each leading zero costs exactly one cycle.
        if (idx_q == '0) begin
          state_d = S_FROM_MONT;
          issue   = 1'b1;
        end else begin
          idx_d = idx_q - CNT_W'(1);
          if (next_bit_c) begin
            state_d = S_SQR;
            issue   = 1'b1;
          end
        end
      end
      S_SQR: begin
        if (bus.mul_done) begin
          a_d = bus.mul_result;
          if (cur_bit_c || ct_q) begin
            state_d = S_MUL;
            issue   = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (bus.mul_done) begin
          // In constant-time mode a zero bit makes this a discarded dummy.
          if (cur_bit_c) begin
            a_d = bus.mul_result;
          end
          advance = 1'b1;
        end
      end
      S_FROM_MONT: begin
        if (bus.mul_done) begin
          result_d = bus.mul_result;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == '0) begin
        state_d = S_FROM_MONT;
      end else begin
        idx_d   = idx_q - CNT_W'(1);
        state_d = S_SQR;
      end
      issue = 1'b1;
    end

    // Operands are captured on entry and held until the multiplier answers.
    if (issue) begin
      mul_start_d = 1'b1;
      case (state_d)
        S_TO_MONT: begin
          mul_a_d = x_d;
          mul_b_d = r2modm_d;
        end
        S_SQR: begin
          mul_a_d = a_d;
          mul_b_d = a_d;
        end
        S_MUL: begin
          mul_a_d = a_d;
          mul_b_d = xm_d;
        end
        default: begin
          mul_a_d = a_d;
          mul_b_d = WIDTH'(1);
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_modexp_ctrl_param.sv
// Bench for modexp_ctrl_param: behavioural Montgomery multiplier with random
// latency, plain modular-power reference model.
module tb_modexp_ctrl_param;

  localparam int unsigned W  = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned M  = 239;

  logic clk;
  logic reset;

  modexp_ctrl_param_if #(.WIDTH(W), .EXP_WIDTH(EW)) bif ();

  modexp_ctrl_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int tests;
  int fails;
  int cyc;
  int mul_cnt;
  int lat_sum;
  int done_cnt;
  int exp_done;
  int stab_err;
  int unsigned rm, r2, rinv;

  logic          pending;
  int            cnt;
  logic [W-1:0]  cap_a, cap_b;
  logic [W-1:0]  ops_a [64];
  logic          spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int unsigned mont(input int unsigned a, input int unsigned b);
    longint unsigned p;
    p = (longint'(a) * longint'(b)) % M;
    return int'((p * rinv) % M);
  endfunction

  function automatic int unsigned powmod(input int unsigned x, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * (x % M)) % M;
    return r;
  endfunction

  // Behavioural Montgomery multiplier, driven away from the active edge.
  always @(negedge clk) begin
    if (bif.done === 1'b1) done_cnt++;
    if (reset) begin
      pending        = 1'b0;
      bif.mul_done   = 1'b0;
      bif.mul_result = '0;
    end else begin
      bif.mul_done = spur;
      spur = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          if (bif.mul_a !== cap_a || bif.mul_b !== cap_b) stab_err++;
          bif.mul_done   = 1'b1;
          bif.mul_result = W'(mont(32'(cap_a), 32'(cap_b)));
          pending        = 1'b0;
        end
      end
      if (bif.mul_start === 1'b1) begin
        pending = 1'b1;
        cnt     = int'($urandom_range(20, 3));
        lat_sum += cnt;
        if (mul_cnt < 64) ops_a[mul_cnt] = bif.mul_a;
        mul_cnt++;
        cap_a = bif.mul_a;
        cap_b = bif.mul_b;
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] x, input logic [EW-1:0] e, input logic ct);
    @(posedge clk); #1;
    bif.x          = x;
    bif.exponent   = e;
    bif.const_time = ct;
    bif.rmodm      = W'(rm);
    bif.r2modm     = W'(r2);
    bif.start      = 1'b1;
    mul_cnt        = 0;
    lat_sum        = 0;
  endtask

  task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e, input logic ct,
                     input bit mid_start, input string tag);
    int t0, n, lv, pc, exp_mul, exp_scan, viol, mi;
    drive_start(x, e, ct);
    t0 = cyc;
    @(posedge clk); #1;
    bif.start    = 1'b0;
    bif.x        = W'($urandom);
    bif.exponent = EW'($urandom);
    n = 0;
    while (bif.done !== 1'b1 && n < 5000) begin
      bif.start = (mid_start && (cyc - t0) == 40) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bif.start = 1'b0;
    check({tag, "_done_seen"}, longint'(bif.done === 1'b1), 1);
    exp_done++;
    lv = 0;
    pc = 0;
    for (int i = 0; i < int'(EW); i++) begin
      if (e[i]) begin
        lv = i + 1;
        pc++;
      end
    end
    exp_mul  = ct ? 2 + 2 * int'(EW) : 2 + lv + pc;
    exp_scan = ct ? 0 : int'(EW) - lv;
    check({tag, "_result"}, longint'(bif.result), longint'(powmod(32'(x), 32'(e))));
    check({tag, "_muls"}, mul_cnt, exp_mul);
    check({tag, "_latency"}, cyc - t0, lat_sum + exp_mul + exp_scan + 1);
    check({tag, "_busy_done"}, longint'(bif.busy), 0);
    if (ct) begin
      viol = 0;
      for (int b = 0; b < int'(EW); b++) begin
        if (!e[b]) begin
          mi = 2 + 2 * (int'(EW) - 1 - b);
          if (ops_a[mi+1] !== ops_a[mi]) viol++;
        end
      end
      check({tag, "_dummy_hold"}, viol, 0);
    end
  endtask

  initial begin
    int n;
    tests = 0; fails = 0; cyc = 0; mul_cnt = 0; lat_sum = 0;
    done_cnt = 0; exp_done = 0; stab_err = 0;
    pending = 1'b0; cnt = 0; spur = 1'b0; cap_a = '0; cap_b = '0;
    reset = 1'b1;
    bif.start = 1'b0; bif.const_time = 1'b0; bif.x = '0; bif.exponent = '0;
    bif.rmodm = '0; bif.r2modm = '0;

    rm = 65536 % M;
    r2 = (rm * rm) % M;
    rinv = 0;
    for (int unsigned i = 1; i < M; i++) if (((rm * i) % M) == 1) rinv = i;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(bif.busy), 0);
    check("rst_done", longint'(bif.done), 0);
    check("rst_mul_start", longint'(bif.mul_start), 0);
    check("rst_result", longint'(bif.result), 0);
    check("rst_mul_a", longint'(bif.mul_a), 0);
    check("rst_mul_b", longint'(bif.mul_b), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run(16'd5, 8'h0D, 1'b0, 1'b0, "n_0d");
    run(16'd5, 8'h0D, 1'b1, 1'b0, "c_0d");
    run(16'd77, 8'h00, 1'b0, 1'b0, "n_e0");
    run(16'd77, 8'h00, 1'b1, 1'b0, "c_e0");
    run(16'd2, 8'hFF, 1'b0, 1'b1, "n_ff_mid");

    // Abort during the fifth multiply wait.
    drive_start(16'd5, 8'h0D, 1'b0);
    @(posedge clk); #1;
    bif.start = 1'b0;
    n = 0;
    while (mul_cnt < 5 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach_5th", mul_cnt, 5);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_busy", longint'(bif.busy), 0);
    check("abort_mul_start", longint'(bif.mul_start), 0);
    check("abort_result", longint'(bif.result), 0);
    check("abort_mul_a", longint'(bif.mul_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, exp_done);
    run(16'd5, 8'h0D, 1'b0, 1'b0, "after_abort");

    // Spurious multiplier pulse while idle must not wake the controller.
    @(posedge clk); #1;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_busy", longint'(bif.busy), 0);
    check("spur_mul_start", longint'(mul_cnt), 2 + 4 + 3);
    check("spur_no_done", done_cnt, exp_done);
    run(16'd5, 8'h0D, 1'b0, 1'b0, "post_spur");
    run(16'd9, 8'hA5, 1'b1, 1'b0, "b2b");

    for (int k = 0; k < 6; k++) begin
      run(W'($urandom_range(M - 1, 0)), EW'($urandom), 1'($urandom), 1'b0, "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", done_cnt, exp_done);
    check("operand_stability", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
